// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: channel count,
// select width, FSM state type and one-hot helper.
package mux_sched_pkg;

    localparam int CH_N  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    function automatic logic [CH_N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [CH_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set req bit scanning ptr+1 .. ptr+4 (mod 4),
// so the channel at ptr itself is considered last.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [CH_N-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int i = 1; i <= CH_N; i++) begin
            if (!found && req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux among four requesters, with a
// burst cap on how long a single owner keeps the channel.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate as soon as any req is set
//   GRANT | owner in owner_ptr holds the channel; cnt counts burst cycles
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH_N-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic [CH_N-1:0]  gnt,
    output logic             active,
    output logic [SEL_W-1:0] owner_ptr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    sched_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] sel_nxt, ptr_nxt;
    logic [CH_N-1:0]  gnt_nxt;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             load;

    // owner_ptr doubles as the scan origin: in GRANT it is the current owner.
    rr_pick4 u_pick (
        .req   (req),
        .ptr   (owner_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        ptr_nxt   = owner_ptr;
        load      = 1'b0;

        case (state)
            IDLE: begin
                if (pick_found) load = 1'b1;
            end
            GRANT: begin
                if (!req[owner_ptr] || cnt == CNT_LAST) begin
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase

        // Handover loads the new owner directly, no idle cycle in between.
        if (load) begin
            state_nxt = GRANT;
            gnt_nxt   = onehot(pick_idx);
            sel_nxt   = pick_idx;
            ptr_nxt   = pick_idx;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= '0;
            gnt       <= '0;
            owner_ptr <= SEL_W'(CH_N - 1);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            owner_ptr <= ptr_nxt;
        end
    end

    assign active = |gnt;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: directed scenarios plus random traffic against a
// per-cycle behavioural model, on a BURST_LEN=4 and a BURST_LEN=1 instance.
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [1:0] sel_a, sel_b, ptr_a, ptr_b;
    logic [3:0] gnt_a, gnt_b;
    logic       active_a, active_b;

    int n_pass  = 0;
    int n_total = 0;

    // Model state per instance: current owner (-1 = none), pointer,
    // cycles the owner has held the grant, last select value.
    int m_owner[2];
    int m_ptr[2];
    int m_held[2];
    int m_sel[2];
    int m_burst[2] = '{4, 1};

    always #5 clk = ~clk;

    mux_rr_sched #(.BURST_LEN(4), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .sel(sel_a), .gnt(gnt_a), .active(active_a), .owner_ptr(ptr_a)
    );

    mux_rr_sched #(.BURST_LEN(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .sel(sel_b), .gnt(gnt_b), .active(active_b), .owner_ptr(ptr_b)
    );

    function automatic int scan(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [3:0] r, input logic rs);
        int w;
        if (rs) begin
            m_owner[d] = -1;
            m_ptr[d]   = 3;
            m_held[d]  = 0;
            m_sel[d]   = 0;
        end else if (m_owner[d] >= 0 && r[m_owner[d]] && m_held[d] < m_burst[d]) begin
            m_held[d]++;
        end else begin
            w = scan(r, m_ptr[d]);
            if (w >= 0) begin
                m_owner[d] = w;
                m_ptr[d]   = w;
                m_sel[d]   = w;
                m_held[d]  = 1;
            end else begin
                m_owner[d] = -1;
                m_held[d]  = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int d);
        return (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
    endfunction

    task automatic step(input logic [3:0] ra, input logic [3:0] rb, input logic rs);
        rst   = rs;
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        model_step(0, ra, rs);
        model_step(1, rb, rs);
        #1;
    endtask

    task automatic test_reset();
        step(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 4'b0000, 1'b0);
            n_total++;
            if (gnt_a !== 4'b0000 || sel_a !== 2'd0 || active_a !== 1'b0 || ptr_a !== 2'd3)
                $display("FAIL reset_idle cyc%0d: got gnt=%b sel=%0d act=%b ptr=%0d want 0000/0/0/3",
                         i, gnt_a, sel_a, active_a, ptr_a);
            else n_pass++;
        end
    endtask

    task automatic test_sole();
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0001, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b0001 || active_a !== 1'b1)
            $display("FAIL sole_latency: got gnt=%b act=%b want 0001/1", gnt_a, active_a);
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            step(4'b0001, 4'b0000, 1'b0);
            n_total++;
            if (gnt_a !== 4'b0001 || sel_a !== 2'd0 || ptr_a !== 2'd0 || gnt_a !== exp_gnt(0))
                $display("FAIL sole_regrant cyc%0d: got gnt=%b sel=%0d ptr=%0d want 0001/0/0",
                         i, gnt_a, sel_a, ptr_a);
            else n_pass++;
        end
    endtask

    task automatic test_all_req();
        int ch;
        step(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 4'b0000, 1'b0);
            ch = (i / 4) % 4;
            n_total++;
            if (gnt_a !== 4'(1 << ch) || sel_a !== 2'(ch) || ptr_a !== 2'(ch))
                $display("FAIL all_req cyc%0d: got gnt=%b sel=%0d ptr=%0d want ch%0d",
                         i, gnt_a, sel_a, ptr_a, ch);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b0100)
            $display("FAIL drop_setup: got gnt=%b want 0100", gnt_a);
        else n_pass++;
        step(4'b1001, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b1000 || ptr_a !== 2'd3 || sel_a !== 2'd3)
            $display("FAIL drop_handover: got gnt=%b ptr=%0d sel=%0d want 1000/3/3",
                     gnt_a, ptr_a, sel_a);
        else n_pass++;
        step(4'b0000, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b0000 || active_a !== 1'b0 || sel_a !== 2'd3)
            $display("FAIL idle_sel_hold: got gnt=%b act=%b sel=%0d want 0000/0/3",
                     gnt_a, active_a, sel_a);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b0);
        step(4'b0010, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b0010)
            $display("FAIL midrst_setup: got gnt=%b want 0010", gnt_a);
        else n_pass++;
        step(4'b0010, 4'b0000, 1'b1);
        n_total++;
        if (gnt_a !== 4'b0000 || active_a !== 1'b0 || ptr_a !== 2'd3 || sel_a !== 2'd0)
            $display("FAIL midrst_clear: got gnt=%b act=%b ptr=%0d sel=%0d want 0000/0/3/0",
                     gnt_a, active_a, ptr_a, sel_a);
        else n_pass++;
        step(4'b0011, 4'b0000, 1'b0);
        n_total++;
        if (gnt_a !== 4'b0001 || ptr_a !== 2'd0)
            $display("FAIL midrst_regrant: got gnt=%b ptr=%0d want 0001/0", gnt_a, ptr_a);
        else n_pass++;
    endtask

    task automatic test_burst1();
        step(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b0101, 1'b0);
            n_total++;
            if (gnt_b !== ((i % 2 == 0) ? 4'b0001 : 4'b0100) ||
                sel_b !== ((i % 2 == 0) ? 2'd0 : 2'd2) || $countones(gnt_b) != 1)
                $display("FAIL burst1_alt cyc%0d: got gnt=%b sel=%0d want %s",
                         i, gnt_b, sel_b, (i % 2 == 0) ? "0001/0" : "0100/2");
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb, g;
        logic [1:0] s, p;
        logic       a, rs;
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 49) == 0);
            step(ra, rb, rs);
            for (int d = 0; d < 2; d++) begin
                g = d ? gnt_b : gnt_a;
                s = d ? sel_b : sel_a;
                p = d ? ptr_b : ptr_a;
                a = d ? active_b : active_a;
                n_total++;
                if (g !== exp_gnt(d) || s !== 2'(m_sel[d]) || p !== 2'(m_ptr[d]) ||
                    a !== (m_owner[d] >= 0) || $countones(g) > 1)
                    $display("FAIL random d%0d cyc%0d: got gnt=%b sel=%0d ptr=%0d act=%b want gnt=%b sel=%0d ptr=%0d",
                             d, i, g, s, p, a, exp_gnt(d), m_sel[d], m_ptr[d]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #1;
        test_reset();
        test_sole();
        test_all_req();
        test_drop();
        test_mid_reset();
        test_burst1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
